// File: rtl/test_value_uart_tx_if.sv
// Signal bundle between the debug-value source and the UART reporter.
interface test_value_uart_tx_if;
  logic [15:0] test_value;
  logic        tx;
  logic        busy;
  logic [7:0]  msg_count;

  modport master (output test_value, input tx, busy, msg_count);
  modport slave  (input test_value, output tx, busy, msg_count);
endinterface

// File: rtl/test_value_uart_tx.sv
// Reports each new test_value as "HHHH\r\n" over an 8N1 UART line, LSB first.
module test_value_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input logic            clk,
  input logic            reset,
  test_value_uart_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] baud;
  logic [15:0] snapshot;
  logic [15:0] last_sent;
  logic [2:0]  bit_idx;
  logic [2:0]  char_idx;
  logic [7:0]  cur_byte;
  logic        tx_r;
  logic        busy_r;
  logic [7:0]  count_r;
  logic        bit_end;
  logic        trigger;

  assign bus.tx        = tx_r;
  assign bus.busy      = busy_r;
  assign bus.msg_count = count_r;

  assign bit_end = (baud == BAUD_MAX);
  assign trigger = (bus.test_value != last_sent);

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    cur_byte = 8'h0A;
    case (char_idx)
      3'd0:    cur_byte = hex_ascii(snapshot[15:12]);
      3'd1:    cur_byte = hex_ascii(snapshot[11:8]);
      3'd2:    cur_byte = hex_ascii(snapshot[7:4]);
      3'd3:    cur_byte = hex_ascii(snapshot[3:0]);
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // DONE shares IDLE's compare so a pending value starts one cycle after the
  // last stop bit; busy drops on entry to DONE and msg_count bumps with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud      <= '0;
      snapshot  <= '0;
      last_sent <= '0;
      bit_idx   <= '0;
      char_idx  <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      count_r   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          baud     <= '0;
          bit_idx  <= '0;
          char_idx <= '0;
          if (trigger) begin
            snapshot  <= bus.test_value;
            last_sent <= bus.test_value;
            busy_r    <= 1'b1;
            tx_r      <= 1'b0;
            state     <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx_r    <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_r    <= cur_byte[3'(bit_idx + 3'd1)];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (char_idx < 3'd5) begin
              char_idx <= char_idx + 3'd1;
              tx_r     <= 1'b0;
              state    <= START;
            end else begin
              busy_r  <= 1'b0;
              count_r <= count_r + 8'd1;
              state   <= DONE;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Directed bench for test_value_uart_tx at 4 clocks per bit, with a UART receive monitor.
module tb_test_value_uart_tx;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   start_err;
  int   stop_err;
  logic [7:0] rx_q[$];
  logic       rx_on;
  int         rx_cnt;
  logic [7:0] rx_sh;

  test_value_uart_tx_if bus ();

  test_value_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples once per clock: 4 start samples, 32 data samples, 4 stop samples.
  always @(negedge clk) begin
    if (!reset) begin
      rx_on <= 1'b0;
    end else if (!rx_on) begin
      if (bus.tx === 1'b0) begin
        rx_on  <= 1'b1;
        rx_cnt <= 1;
      end
    end else begin
      if (rx_cnt < 4 && bus.tx !== 1'b0) start_err <= start_err + 1;
      if (rx_cnt >= 4 && rx_cnt < 36 && rx_cnt % 4 == 1) rx_sh[(rx_cnt - 4) / 4] <= bus.tx;
      if (rx_cnt >= 36 && bus.tx !== 1'b1) stop_err <= stop_err + 1;
      if (rx_cnt == 39) begin
        rx_q.push_back(rx_sh);
        rx_on <= 1'b0;
      end
      rx_cnt <= rx_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wait_busy_low(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) done = 1'b1;
    end
    check({tag, "_timeout"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_msg(input string tag, input logic [15:0] v);
    logic [7:0] exp[6];
    logic [7:0] got;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] n = v[15 - 4*i -: 4];
      exp[i] = (n < 10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    end
    exp[4] = 8'h0D;
    exp[5] = 8'h0A;
    for (int i = 0; i < 6; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hXX;
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
    end
  endtask

  task automatic hold_quiet(input string tag, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) lows++;
    end
    check({tag, "_quiet"}, lows, 0);
  endtask

  initial begin
    int blen;
    n_chk = 0; n_pass = 0; start_err = 0; stop_err = 0;
    rx_on = 1'b0; rx_cnt = 0; rx_sh = 8'h00;
    reset = 1'b0;
    bus.test_value = 16'h0000;

    // 1: reset state and quiet line with test_value == 0
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, bus.tx}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_count", {24'd0, bus.msg_count}, 32'd0);
    reset = 1'b1;
    hold_quiet("t1", 1000);
    check("t1_count", {24'd0, bus.msg_count}, 32'd0);

    // 2: first message, latency and busy length
    bus.test_value = 16'h1A2F;
    @(posedge clk); #1;
    check("t2_tx_fall", {31'd0, bus.tx}, 32'd0);
    check("t2_busy_rise", {31'd0, bus.busy}, 32'd1);
    blen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      blen++;
    end
    check("t2_busy_len", blen, 240);
    check("t2_count", {24'd0, bus.msg_count}, 32'd1);
    check_msg("t2", 16'h1A2F);

    // 3: changes during a message are dropped except the latest
    bus.test_value = 16'h0001;
    @(negedge clk);
    repeat (20) @(negedge clk);
    bus.test_value = 16'h0002;
    repeat (50) @(negedge clk);
    bus.test_value = 16'hBEEF;
    wait_busy_low("t3a");
    check("t3a_count", {24'd0, bus.msg_count}, 32'd2);
    @(posedge clk); #1;
    check("t3_restart_tx", {31'd0, bus.tx}, 32'd0);
    check("t3_restart_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    wait_busy_low("t3b");
    check("t3b_count", {24'd0, bus.msg_count}, 32'd3);
    check_msg("t3a", 16'h0001);
    check_msg("t3b", 16'hBEEF);

    // 4: constant value, no retransmission
    hold_quiet("t4", 500);
    check("t4_count", {24'd0, bus.msg_count}, 32'd3);
    check("t4_rxq", rx_q.size(), 0);

    // 5: async reset during bit 3 (a zero) of char 3, then full resend
    bus.test_value = 16'hC3D7;
    @(posedge clk); #1;
    repeat (137) @(posedge clk);
    #2;
    check("t5_pre_tx", {31'd0, bus.tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("t5_rst_tx", {31'd0, bus.tx}, 32'd1);
    check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_rst_count", {24'd0, bus.msg_count}, 32'd0);
    repeat (3) @(negedge clk);
    rx_q.delete();
    reset = 1'b1;
    @(negedge clk);
    wait_busy_low("t5");
    check("t5_count", {24'd0, bus.msg_count}, 32'd1);
    check_msg("t5", 16'hC3D7);

    // 6: 256 messages wrap msg_count
    reset = 1'b0;
    bus.test_value = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      bus.test_value = 16'(i + 1);
      @(negedge clk);
      wait_busy_low($sformatf("t6_%0d", i));
      if (i == 254) check("t6_count255", {24'd0, bus.msg_count}, 32'd255);
    end
    check("t6_wrap", {24'd0, bus.msg_count}, 32'd0);
    check("t6_rxq", rx_q.size(), 1536);
    while (rx_q.size() > 6) void'(rx_q.pop_front());
    check_msg("t6_last", 16'h0100);
    check("start_width", start_err, 0);
    check("stop_width", stop_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
